// File: rtl/core_pkg.sv
// Shared core types: read-response owner encoding and byte-lane count.
package core_pkg;

  localparam int unsigned BYTE_LANES = 4;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_owner_t;

endpackage

// File: rtl/local_ram_arbiter.sv
// local_ram_arbiter: shares the local RAM's single synchronous read port between instruction
// fetch and load/store, and steers the one-cycle read data back to the requester that owns it.
// Data writes go straight to the RAM's separate write port and never block fetch.
// Optional build macro: LOCAL_RAM_ARB_STARVE_GUARD_EN adds a data-read streak counter that
// lets a waiting fetch through after MAX_DATA_STREAK consecutive contested data-read wins.
module local_ram_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_en,
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH-1:0] i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [DATA_WIDTH-1:0] o_f_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [BYTE_LANES-1:0] i_d_be,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_read_data,
  output logic                  o_ram_write_en,
  output logic [BYTE_LANES-1:0] o_ram_byte_en,
  output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
  output logic [DATA_WIDTH-1:0] o_ram_write_data
);

  logic                  grant_ok;
  logic                  fetch_wins;
  logic                  f_rd_acc;
  logic                  d_rd_acc;
  logic [ADDR_WIDTH-1:0] f_word;
  logic [ADDR_WIDTH-1:0] d_word;
  logic [ADDR_WIDTH-1:0] last_read_addr;
  rsp_owner_t            rsp_owner;

  // Grants need the enable and must stay low for the whole time reset is held.
  assign grant_ok = i_clk_en && !i_rst;

  // RAM ports take word indices; byte offset bits are dropped.
  assign f_word = {2'b00, i_f_addr[ADDR_WIDTH-1:2]};
  assign d_word = {2'b00, i_d_addr[ADDR_WIDTH-1:2]};

`ifdef LOCAL_RAM_ARB_STARVE_GUARD_EN
  // +2 keeps the width non-zero even for a streak limit of 0.
  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 2);

  logic [StreakW-1:0] streak_cnt;

  assign fetch_wins = (streak_cnt == StreakW'(MAX_DATA_STREAK));

  // Count data-read wins over a waiting fetch; any fetch grant or idle fetch restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      streak_cnt <= '0;
    end else if (!i_f_req || o_f_gnt) begin
      streak_cnt <= '0;
    end else if (d_rd_acc) begin
      streak_cnt <= streak_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_max_streak;

  assign fetch_wins        = 1'b0;
  assign unused_max_streak = 32'(MAX_DATA_STREAK);
`endif

  // Grant decision: writes never contend; a read collision goes to data unless the guard fires.
  always_comb begin
    o_f_gnt = 1'b0;
    o_d_gnt = 1'b0;
    if (grant_ok) begin
      if (i_d_req && i_d_we) begin
        o_d_gnt = 1'b1;
        o_f_gnt = i_f_req;
      end else if (i_d_req && i_f_req) begin
        o_f_gnt = fetch_wins;
        o_d_gnt = !fetch_wins;
      end else begin
        o_f_gnt = i_f_req;
        o_d_gnt = i_d_req;
      end
    end
  end

  assign f_rd_acc = o_f_gnt;
  assign d_rd_acc = o_d_gnt && !i_d_we;

  // Read-port mux; holds the previous index while the port is idle.
  always_comb begin
    o_ram_read_addr = last_read_addr;
    if (f_rd_acc) begin
      o_ram_read_addr = f_word;
    end else if (d_rd_acc) begin
      o_ram_read_addr = d_word;
    end
  end

  // Remember the last index presented so an idle port keeps it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_read_addr <= '0;
    end else begin
      last_read_addr <= o_ram_read_addr;
    end
  end

  // Owner of next cycle's read data; advances even when gated since the RAM register is not.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_owner <= RSP_NONE;
    end else if (f_rd_acc) begin
      rsp_owner <= RSP_FETCH;
    end else if (d_rd_acc) begin
      rsp_owner <= RSP_DATA;
    end else begin
      rsp_owner <= RSP_NONE;
    end
  end

  assign o_f_rvalid = (rsp_owner == RSP_FETCH);
  assign o_d_rvalid = (rsp_owner == RSP_DATA);
  assign o_f_rdata  = i_ram_read_data;
  assign o_d_rdata  = i_ram_read_data;

  assign o_ram_write_en   = o_d_gnt && i_d_we;
  assign o_ram_byte_en    = i_d_be;
  assign o_ram_write_addr = d_word;
  assign o_ram_write_data = i_d_wdata;

  // Both byte-offset bit pairs are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_f_addr[1:0], i_d_addr[1:0]};

endmodule

// File: tb/tb_local_ram_arbiter.sv
// Self-checking bench for local_ram_arbiter: a behavioural RAM sits behind the DUT and an
// independent golden word array plus a streak count predict grants and read data.
module tb_local_ram_arbiter;
  import core_pkg::*;

`ifdef LOCAL_RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        f_req, f_gnt, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] ram_read_addr, ram_read_data, ram_waddr, ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic        ram_init;

  logic [31:0] mem  [256];
  logic [31:0] gold [256];
  int checks   = 0;
  int failures = 0;
  int m_streak = 0;

  always #5 clk = ~clk;

  local_ram_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MAX_DATA_STREAK(MAX_STREAK)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_clk_en        (clk_en),
    .i_f_req         (f_req),
    .i_f_addr        (f_addr),
    .o_f_gnt         (f_gnt),
    .o_f_rvalid      (f_rvalid),
    .o_f_rdata       (f_rdata),
    .i_d_req         (d_req),
    .i_d_we          (d_we),
    .i_d_be          (d_be),
    .i_d_addr        (d_addr),
    .i_d_wdata       (d_wdata),
    .o_d_gnt         (d_gnt),
    .o_d_rvalid      (d_rvalid),
    .o_d_rdata       (d_rdata),
    .o_ram_read_addr (ram_read_addr),
    .i_ram_read_data (ram_read_data),
    .o_ram_write_en  (ram_we),
    .o_ram_byte_en   (ram_be),
    .o_ram_write_addr(ram_waddr),
    .o_ram_write_data(ram_wdata)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0307);
  endfunction

  function automatic logic [31:0] merge_be(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural local RAM: registered read returns pre-write contents.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_waddr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_read_data <= mem[ram_read_addr[7:0]];
  end

  task automatic drive_idle();
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; clk_en = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_init = 1'b1;
    drive_idle();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    for (int i = 0; i < 256; i++) gold[i] = init_word(i);
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      failures++; $display("FAIL reset_gnt got f=%0b d=%0b exp 0 0", f_gnt, d_gnt); end
    checks++; if (ram_we !== 1'b0) begin
      failures++; $display("FAIL reset_write_en got=%0b exp=0", ram_we); end
    checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL reset_rvalid got f=%0b d=%0b exp 0 0", f_rvalid, d_rvalid); end
    checks++; if (ram_read_addr !== 32'h0) begin
      failures++; $display("FAIL reset_read_addr got=%h exp=0", ram_read_addr); end
    ram_init = 1'b0;
    drive_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL post_reset_rvalid got f=%0b d=%0b", f_rvalid, d_rvalid); end
  endtask

  task automatic test_fetch_single(input logic [31:0] addr, input logic [31:0] word, string nm);
    @(negedge clk);
    drive_idle();
    f_req = 1'b1; f_addr = addr;
    #1;
    checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      failures++; $display("FAIL %s_gnt got f=%0b d=%0b exp 1 0", nm, f_gnt, d_gnt); end
    checks++; if (ram_read_addr !== word) begin
      failures++; $display("FAIL %s_read_addr got=%h exp=%h", nm, ram_read_addr, word); end
    @(posedge clk); #1;
    f_req = 1'b0;
    checks++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL %s_rvalid got f=%0b d=%0b exp 1 0", nm, f_rvalid, d_rvalid); end
    checks++; if (f_rdata !== gold[word[7:0]]) begin
      failures++; $display("FAIL %s_rdata got=%h exp=%h", nm, f_rdata, gold[word[7:0]]); end
  endtask

  task automatic test_write_fetch();
    logic [31:0] old;
    old = gold[8];
    @(negedge clk);
    drive_idle();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    f_req = 1'b1; f_addr = 32'h20;
    #1;
    checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b1) begin
      failures++; $display("FAIL wf_gnt got f=%0b d=%0b exp 1 1", f_gnt, d_gnt); end
    checks++; if (ram_we !== 1'b1 || ram_be !== 4'b0011 || ram_waddr !== 32'd8) begin
      failures++; $display("FAIL wf_write got we=%0b be=%b wa=%h exp 1 0011 8",
                           ram_we, ram_be, ram_waddr); end
    @(posedge clk); #1;
    drive_idle();
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== old || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL wf_old_data got v=%0b %h dv=%0b exp 1 %h 0",
                           f_rvalid, f_rdata, d_rvalid, old); end
    gold[8] = {old[31:16], 16'hBEEF};
    test_fetch_single(32'h20, 32'd8, "wf_new");
  endtask

  task automatic test_streak();
    logic exp_f;
    idle_cycle();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84; clk_en = 1'b1;
      #1;
      exp_f = GUARD && ((c % (MAX_STREAK + 1)) == MAX_STREAK);
      checks++; if (f_gnt !== exp_f || d_gnt !== !exp_f) begin
        failures++; $display("FAIL streak_gnt c=%0d got f=%0b d=%0b exp f=%0b", c, f_gnt, d_gnt,
                             exp_f); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== exp_f || d_rvalid !== !exp_f ||
                    f_rdata !== (exp_f ? gold[16] : gold[33])) begin
        failures++; $display("FAIL streak_rsp c=%0d got fv=%0b dv=%0b data=%h", c, f_rvalid,
                             d_rvalid, f_rdata); end
    end
    idle_cycle();
  endtask

  task automatic test_clk_en();
    idle_cycle();
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
    #1;
    checks++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      failures++; $display("FAIL en_last_gnt got f=%0b d=%0b exp 0 1", f_gnt, d_gnt); end
    @(posedge clk); #1;
    clk_en = 1'b0; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h1234_5678;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== gold[34]) begin
      failures++; $display("FAIL en_late_rvalid got v=%0b %h exp 1 %h", d_rvalid, d_rdata,
                           gold[34]); end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_we !== 1'b0) begin
        failures++; $display("FAIL en_off_gnt c=%0d got f=%0b d=%0b we=%0b exp 0 0 0", c, f_gnt,
                             d_gnt, ram_we); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        failures++; $display("FAIL en_off_rvalid c=%0d got f=%0b d=%0b", c, f_rvalid, d_rvalid);
      end
    end
    idle_cycle();
    test_fetch_single(32'h88, 32'd34, "en_nowrite");
  endtask

  task automatic test_reset_mid_read();
    idle_cycle();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8C;
    @(posedge clk); #1;
    checks++; if (d_rvalid !== 1'b1) begin
      failures++; $display("FAIL rst_pre_rvalid got=%0b exp=1", d_rvalid); end
    rst = 1'b1;
    #1;
    checks++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b0) begin
      failures++; $display("FAIL rst_async_rvalid got v=%0b g=%0b exp 0 0", d_rvalid, d_gnt); end
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (d_rvalid !== 1'b0 || f_rvalid !== 1'b0 || ram_read_addr !== 32'h0) begin
      failures++; $display("FAIL rst_release got dv=%0b fv=%0b ra=%h exp 0 0 0", d_rvalid,
                           f_rvalid, ram_read_addr); end
  endtask

  task automatic test_random();
    logic fp, dp, dwe, en, exp_fg, exp_dg, gfetch, exp_fv, exp_dv;
    logic [31:0] fa, da, dw, exp_ra, exp_data;
    logic [3:0] be;
    fp = 1'b0; dp = 1'b0; dwe = 1'b0; fa = '0; da = '0; dw = '0; be = '0;
    idle_cycle();
    m_streak = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!fp && $urandom_range(0, 1) == 1) begin
        fp = 1'b1; fa = 32'($urandom_range(0, 1023));
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1; dwe = 1'($urandom_range(0, 1)); da = 32'($urandom_range(0, 1023));
        dw = $urandom; be = 4'($urandom_range(0, 15));
      end
      en = ($urandom_range(0, 7) != 0);
      f_req = fp; f_addr = fa; d_req = dp; d_we = dwe; d_addr = da; d_wdata = dw; d_be = be;
      clk_en = en;
      #1;
      gfetch = GUARD && (m_streak == MAX_STREAK);
      exp_dg = en && dp && (dwe || !fp || !gfetch);
      exp_fg = en && fp && (!dp || dwe || gfetch);
      checks++; if (f_gnt !== exp_fg || d_gnt !== exp_dg) begin
        failures++; $display("FAIL rand_gnt c=%0d got f=%0b d=%0b exp f=%0b d=%0b", c, f_gnt,
                             d_gnt, exp_fg, exp_dg); end
      exp_fv = exp_fg;
      exp_dv = exp_dg && !dwe;
      exp_ra = exp_fv ? (fa >> 2) : (da >> 2);
      exp_data = gold[exp_ra[7:0]];
      if (exp_fv || exp_dv) begin
        checks++; if (ram_read_addr !== exp_ra) begin
          failures++; $display("FAIL rand_read_addr c=%0d got=%h exp=%h", c, ram_read_addr,
                               exp_ra); end
      end
      checks++; if (ram_we !== (exp_dg && dwe)) begin
        failures++; $display("FAIL rand_write_en c=%0d got=%0b exp=%0b", c, ram_we,
                             exp_dg && dwe); end
      if (exp_dg && dwe) gold[da[9:2]] = merge_be(gold[da[9:2]], dw, be);
      if (!fp || exp_fg) m_streak = 0;
      else if (exp_dv) m_streak++;
      @(posedge clk); #1;
      checks++; if (f_rvalid !== exp_fv || d_rvalid !== exp_dv) begin
        failures++; $display("FAIL rand_rvalid c=%0d got f=%0b d=%0b exp f=%0b d=%0b", c,
                             f_rvalid, d_rvalid, exp_fv, exp_dv); end
      if (exp_fv || exp_dv) begin
        checks++; if ((exp_fv ? f_rdata : d_rdata) !== exp_data) begin
          failures++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c,
                               exp_fv ? f_rdata : d_rdata, exp_data); end
      end
      if (exp_fg) fp = 1'b0;
      if (exp_dg) dp = 1'b0;
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch_single(32'h0000_0010, 32'd4, "fetch_alone");
    test_write_fetch();
    test_streak();
    test_clk_en();
    test_reset_mid_read();
    test_fetch_single(32'h0000_0013, 32'd4, "low_bits");
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/local_ram_arbiter.md
# local_ram_arbiter

Two-requester access scheduler in front of the core's byte-enabled local RAM, which has one synchronous read port and one write port. Shares the single read port between the instruction-fetch path and the load/store data path and routes the one-cycle-latency read data back to the correct requester. Data writes use the RAM's separate write port, so they never block fetch. Sits between the core pipeline and `local_ram`; the RAM is instantiated alongside it, not inside it.

## Interface
- ADDR_WIDTH, 32, byte-address width of both requester ports
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes)
- MAX_DATA_STREAK, 4, consecutive data-read wins allowed while fetch waits (starvation guard only)

- i_clk  in  1  core clock
- i_rst  in  1  asynchronous, active-high reset
- i_clk_en  in  1  global clock enable; no grants while low
- i_f_req / i_f_addr  in  1 / ADDR_WIDTH  fetch read request, byte address
- o_f_gnt  out  1  fetch request accepted this cycle
- o_f_rvalid / o_f_rdata  out  1 / DATA_WIDTH  fetch read response
- i_d_req / i_d_we  in  1 / 1  data request; 1 = write
- i_d_be / i_d_addr / i_d_wdata  in  4 / ADDR_WIDTH / DATA_WIDTH  byte enables, byte address, write data
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid / o_d_rdata  out  1 / DATA_WIDTH  data read response (reads only)
- o_ram_read_addr  out  ADDR_WIDTH  word index to RAM read port
- i_ram_read_data  in  DATA_WIDTH  RAM registered read data
- o_ram_write_en / o_ram_byte_en / o_ram_write_addr / o_ram_write_data  out  1 / 4 / ADDR_WIDTH / DATA_WIDTH  RAM write port

## Operation
- Word index = byte address >> 2 on both RAM ports; address bits [1:0] are ignored; the upper 2 bits are zero-filled.
- Handshake: a request is accepted when req && gnt. gnt is combinational from current requests and state. A requester holds req and its fields stable until it sees gnt.
- Grants are issued only while i_clk_en = 1; otherwise both gnt = 0 and o_ram_write_en = 0.
- Data write: always granted. o_ram_write_en = 1 with byte_en = i_d_be; be = 0 is granted and writes nothing. No rvalid is generated for a write. A fetch in the same cycle is also granted.
- Data read vs fetch: an uncontested request is granted. When both are pending, data wins by default (see Configuration).
- Read-port mux: when the RAM read port is idle, o_ram_read_addr holds its last value.
- Response owner register `rsp_owner` ∈ {RSP_NONE, RSP_FETCH, RSP_DATA} is set on the cycle after a read accept:
  - RSP_FETCH → o_f_rvalid = 1, o_f_rdata = i_ram_read_data.
  - RSP_DATA → the same on the data side.
  - RSP_NONE → both rvalid = 0.
- rdata outputs pass i_ram_read_data unconditionally; they are valid only with rvalid.
- Same-cycle write and fetch read to the same word: the fetch returns the old data. No forwarding.

## Timing
- Reset values:
  - o_f_rvalid = o_d_rvalid = 0, rsp_owner = RSP_NONE, streak counter = 0.
  - o_ram_write_en = 0, o_ram_read_addr = 0.
  - gnt outputs 0 while i_rst is asserted.
- Read latency is exactly 1 cycle from accept to rvalid, with back-to-back accepts every cycle.
- rsp_owner advances every clock regardless of i_clk_en, because the RAM read register is ungated. A read accepted in the last enabled cycle still responds.
- Reset mid-read drops the outstanding response; no rvalid follows reset release.

## Configuration
- LOCAL_RAM_ARB_STARVE_GUARD_EN defined:
  - An internal counter increments on each data-read grant while i_f_req = 1 and is not granted.
  - Once the counter equals MAX_DATA_STREAK, the next contested cycle grants fetch instead.
  - The counter clears on any fetch grant or on any cycle with i_f_req = 0.
- Not defined: strict data priority, counter absent, MAX_DATA_STREAK unused.

## Structure
- Shared package `core_pkg`: `rsp_owner_t` enum (RSP_NONE, RSP_FETCH, RSP_DATA) and the `BYTE_LANES = 4` constant.
- No sub-module; grant logic, owner register and streak counter live in one module.

## Test plan
- Reset, then fetch 0x0000_0010 alone → o_f_gnt = 1, o_ram_read_addr = 4, next cycle o_f_rvalid = 1 with RAM word 4; o_d_rvalid = 0.
- Data write 0xDEAD_BEEF to 0x20 with be = 4'b0011, plus a concurrent fetch of 0x20 → both granted, RAM word 8 low half = 0xBEEF, fetch returns old word.
- Fetch and data read pending continuously with guard enabled and MAX_DATA_STREAK = 4 → 4 data grants, then 1 fetch grant, repeating. With guard disabled → fetch never granted.
- i_clk_en = 0 for 3 cycles with both requests pending → no gnt and no write_en. A read accepted just before the enable dropped still gives rvalid 1 cycle later.
- Assert i_rst asynchronously in the cycle after a data-read accept → o_d_rvalid = 0 immediately and after release; rsp_owner = RSP_NONE.
- Byte address 0x0000_0013 → o_ram_read_addr = 4 (low bits ignored).
